// File: rtl/alu_seq_ctrl.sv
// Sequences one P -> I -> S control-law pass through the ALU, owning Accum and the result register.
// Optional single-step gating of P/I/S via the ALU_SEQ_STEP_EN macro.
module alu_seq_ctrl #(
  parameter int         MUL_CYC     = 2,
  parameter logic [2:0] SRC1_ACCUM  = 3'b000,
  parameter logic [2:0] SRC1_ERR    = 3'b010,
  parameter logic [2:0] SRC0_INTGRL = 3'b001,
  parameter logic [2:0] SRC0_ICOMP  = 3'b010,
  parameter logic [2:0] SRC0_PCOMP  = 3'b011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
`ifdef ALU_SEQ_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] dst,
  output logic [2:0]  src1sel,
  output logic [2:0]  src0sel,
  output logic        multiply,
  output logic        saturate,
  output logic        mult2,
  output logic        mult4,
  output logic        sub,
  output logic [15:0] Accum,
  output logic [15:0] result,
  output logic        result_vld,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P,
    ST_I,
    ST_S,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MUL_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       cap;
  logic       adv;

  logic [2:0] src1sel_nxt, src0sel_nxt;
  logic       multiply_nxt, saturate_nxt, mult2_nxt, sub_nxt, busy_nxt, vld_nxt;

`ifdef ALU_SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cap marks the edge on which a step finishes and dst must be latched.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 4'd0;
    cap       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_P;
      end
      ST_P: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = cnt;
          if (adv) begin
            state_nxt = ST_I;
            cnt_nxt   = 4'd0;
            cap       = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_I: begin
        if (adv) begin
          state_nxt = ST_S;
          cap       = 1'b1;
        end
      end
      ST_S: begin
        if (adv) begin
          state_nxt = ST_DONE;
          cap       = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = go ? ST_P : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register cleanly at step entry.
  always_comb begin
    src1sel_nxt  = 3'b000;
    src0sel_nxt  = 3'b000;
    multiply_nxt = 1'b0;
    saturate_nxt = 1'b0;
    mult2_nxt    = 1'b0;
    sub_nxt      = 1'b0;
    busy_nxt     = 1'b0;
    vld_nxt      = 1'b0;
    case (state_nxt)
      ST_P: begin
        src1sel_nxt  = SRC1_ERR;
        src0sel_nxt  = SRC0_PCOMP;
        multiply_nxt = 1'b1;
        busy_nxt     = 1'b1;
      end
      ST_I: begin
        src1sel_nxt  = SRC1_ACCUM;
        src0sel_nxt  = SRC0_INTGRL;
        saturate_nxt = 1'b1;
        mult2_nxt    = 1'b1;
        busy_nxt     = 1'b1;
      end
      ST_S: begin
        src1sel_nxt  = SRC1_ACCUM;
        src0sel_nxt  = SRC0_ICOMP;
        saturate_nxt = 1'b1;
        sub_nxt      = 1'b1;
        busy_nxt     = 1'b1;
      end
      ST_DONE: vld_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1sel    <= 3'b000;
      src0sel    <= 3'b000;
      multiply   <= 1'b0;
      saturate   <= 1'b0;
      mult2      <= 1'b0;
      mult4      <= 1'b0;
      sub        <= 1'b0;
      busy       <= 1'b0;
      result_vld <= 1'b0;
      Accum      <= 16'h0000;
      result     <= 16'h0000;
    end else begin
      src1sel    <= src1sel_nxt;
      src0sel    <= src0sel_nxt;
      multiply   <= multiply_nxt;
      saturate   <= saturate_nxt;
      mult2      <= mult2_nxt;
      mult4      <= 1'b0;
      sub        <= sub_nxt;
      busy       <= busy_nxt;
      result_vld <= vld_nxt;
      if (cap) Accum <= dst;
      if (cap && state == ST_S) result <= dst;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: nominal pass, back-to-back go, mid-sequence reset, MUL_CYC=4, optional stepping.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, go4;
  logic [15:0] dst, dst4;
`ifdef ALU_SEQ_STEP_EN
  logic        step, step4;
`endif

  logic [2:0]  src1sel, src0sel, src1sel4, src0sel4;
  logic        multiply, saturate, mult2, mult4, sub, busy, result_vld;
  logic        multiply4, saturate4, mult24, mult44, sub4, busy4, result_vld4;
  logic [15:0] Accum, result, Accum4, result4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.MUL_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
`ifdef ALU_SEQ_STEP_EN
    .step(step),
`endif
    .dst(dst), .src1sel(src1sel), .src0sel(src0sel), .multiply(multiply),
    .saturate(saturate), .mult2(mult2), .mult4(mult4), .sub(sub),
    .Accum(Accum), .result(result), .result_vld(result_vld), .busy(busy)
  );

  alu_seq_ctrl #(.MUL_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .go(go4),
`ifdef ALU_SEQ_STEP_EN
    .step(step4),
`endif
    .dst(dst4), .src1sel(src1sel4), .src0sel(src0sel4), .multiply(multiply4),
    .saturate(saturate4), .mult2(mult24), .mult4(mult44), .sub(sub4),
    .Accum(Accum4), .result(result4), .result_vld(result_vld4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // {src1sel, src0sel, multiply, saturate, mult2, mult4, sub, busy, result_vld}
  function automatic logic [15:0] cw();
    return {3'b000, src1sel, src0sel, multiply, saturate, mult2, mult4, sub, busy, result_vld};
  endfunction

  localparam logic [15:0] CW_ZERO = 16'h0000;
  localparam logic [15:0] CW_P    = {3'b000, 3'b010, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] CW_I    = {3'b000, 3'b000, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] CW_S    = {3'b000, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [15:0] CW_DONE = 16'h0001;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vld_cnt;
    int mul_cnt;
    int vld_at;
    rst_n = 1'b0;
    go    = 1'b0;
    go4   = 1'b0;
    dst   = 16'h0000;
    dst4  = 16'h0000;
`ifdef ALU_SEQ_STEP_EN
    step  = 1'b1;
    step4 = 1'b1;
`endif
    #3;
    check("reset_cw", cw(), CW_ZERO);
    check("reset_accum", Accum, 16'h0000);
    check("reset_result", result, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal pass
    go = 1'b1; dst = 16'h0010;
    tick();
    go = 1'b0;
    check("nom_p0_cw", cw(), CW_P);
    tick();
    check("nom_p1_cw", cw(), CW_P);
    tick();
    check("nom_i_cw", cw(), CW_I);
    check("nom_accum_p", Accum, 16'h0010);
    dst = 16'h0030;
    tick();
    check("nom_s_cw", cw(), CW_S);
    check("nom_accum_i", Accum, 16'h0030);
    dst = 16'h0020;
    tick();
    check("nom_done_cw", cw(), CW_DONE);
    check("nom_result", result, 16'h0020);
    check("nom_accum_s", Accum, 16'h0020);
    tick();
    check("nom_idle_cw", cw(), CW_ZERO);
    check("nom_result_hold", result, 16'h0020);

    // go held high: back-to-back sequences, one pulse each
    go = 1'b1; dst = 16'h0042;
    vld_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_vld) vld_cnt++;
      if (i == 5) check("b2b_restart_p", cw(), CW_P);
    end
    go = 1'b0;
    check("b2b_vld_count", 16'(vld_cnt), 16'd2);
    check("b2b_result", result, 16'h0042);
    tick();
    check("b2b_idle_cw", cw(), CW_ZERO);

    // Reset during I aborts without a result
    dst = 16'h7FFF; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check("rst_in_i_cw", cw(), CW_I);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_accum", Accum, 16'h0000);
    check("rst_mid_result", result, 16'h0000);
    check("rst_mid_cw", cw(), CW_ZERO);
    tick();
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (result_vld) vld_cnt++;
    end
    check("rst_no_vld", 16'(vld_cnt), 16'd0);
    dst = 16'h0005; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_rerun_vld", 16'(result_vld), 16'd1);
    check("rst_rerun_result", result, 16'h0005);

    // MUL_CYC=4 instance
    dst4 = 16'h0abc; go4 = 1'b1;
    mul_cnt = 0;
    vld_at  = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      go4 = 1'b0;
      if (multiply4) mul_cnt++;
      if (result_vld4) vld_at = i;
    end
    check("mc4_mul_cycles", 16'(mul_cnt), 16'd4);
    check("mc4_vld_cycle", 16'(vld_at), 16'd6);
    check("mc4_result", result4, 16'h0abc);
    check("mc4_mult4", 16'(mult44), 16'd0);

`ifdef ALU_SEQ_STEP_EN
    // Stepping: I held while step is low
    tick();
    dst = 16'h0011; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check("step_i_cw", cw(), CW_I);
    check("step_accum_p", Accum, 16'h0011);
    step = 1'b0; dst = 16'h1234;
    mul_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cw() != CW_I || Accum != 16'h0011) mul_cnt++;
    end
    check("step_hold_bad_cycles", 16'(mul_cnt), 16'd0);
    step = 1'b1;
    tick();
    check("step_s_cw", cw(), CW_S);
    check("step_accum_i", Accum, 16'h1234);
    tick();
    check("step_done_result", result, 16'h1234);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
